// File: rtl/fft_reorder_pkg.sv
// Shared constants and helpers for the FFT output reorder buffer: read FSM
// encodings, a constant log2 and a bit-reversal of the low 'bits' bits.
package fft_reorder_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Bits above 'bits' come back as zero so callers can truncate freely.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int bits);
    logic [31:0] result;
    result = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < bits) result = result | (32'(value[i]) << (bits - 1 - i));
    end
    return result;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM for the reorder buffer: one write port, one
// registered read port, no reset on contents or read data.
module reorder_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int DW    = 32
) (
  input  logic          clock,
  input  logic          i_wrEn,
  input  logic [AW-1:0] i_wrAddr,
  input  logic [DW-1:0] i_wrData,
  input  logic          i_rdEn,
  input  logic [AW-1:0] i_rdAddr,
  output logic [DW-1:0] o_rdData
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_wrEn) r_mem[i_wrAddr] <= i_wrData;
    if (i_rdEn) o_rdData <= r_mem[i_rdAddr];
  end

endmodule

// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer after the SDF FFT chain: frames arrive in
// bit-reversed order and leave in natural order with no inter-frame gaps.
module fft_reorder
  import fft_reorder_pkg::*;
#(
  parameter int N     = 64,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
);

  localparam int LOG_N = log2(N);

  logic [LOG_N-1:0]   r_wrCount;
  logic               r_wrBank;
  logic [1:0]         r_full;
  logic [0:0]         r_state;
  logic [LOG_N-1:0]   r_rdCount;
  logic               r_rdBank;
  logic               r_issueD;

  logic               w_wrLast;
  logic               w_issue;
  logic               w_rdLast;
  logic [1:0]         w_setMask;
  logic [1:0]         w_clrMask;
  logic [LOG_N:0]     w_wrAddr;
  logic [LOG_N:0]     w_rdAddr;
  logic [2*WIDTH-1:0] w_ramQ;

  assign w_wrLast = di_en && (r_wrCount == LOG_N'(N - 1));
  assign w_wrAddr = {r_wrBank, LOG_N'(bitrev(32'(r_wrCount), LOG_N))};
  assign w_rdAddr = {r_rdBank, r_rdCount};

  // IDLE issues address 0 in the same cycle it sees a full bank, which keeps
  // the latency at N+1 and lets a freshly filled bank follow without a bubble.
  always_comb begin
    w_issue  = 1'b0;
    w_rdLast = 1'b0;
    if (r_state == ST_IDLE) begin
      w_issue = r_full[r_rdBank];
    end else begin
      w_issue  = 1'b1;
      w_rdLast = (r_rdCount == LOG_N'(N - 1));
    end
  end

  assign w_setMask = w_wrLast ? (r_wrBank ? 2'b10 : 2'b01) : 2'b00;
  assign w_clrMask = w_rdLast ? (r_rdBank ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wrCount <= '0;
      r_wrBank  <= 1'b0;
    end else if (di_en) begin
      r_wrCount <= r_wrCount + LOG_N'(1);
      if (w_wrLast) r_wrBank <= ~r_wrBank;
    end else begin
      r_wrCount <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_full <= 2'b00;
    end else begin
      r_full <= (r_full | w_setMask) & ~w_clrMask;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_rdCount <= '0;
      r_rdBank  <= 1'b0;
    end else begin
      if (w_issue) r_rdCount <= r_rdCount + LOG_N'(1);
      if (r_state == ST_IDLE) begin
        if (w_issue) r_state <= ST_READ;
      end else if (w_rdLast) begin
        r_state  <= ST_IDLE;
        r_rdBank <= ~r_rdBank;
      end
    end
  end

  reorder_ram #(
    .DEPTH (2 * N),
    .AW    (LOG_N + 1),
    .DW    (2 * WIDTH)
  ) u_ram (
    .clock    (clock),
    .i_wrEn   (di_en),
    .i_wrAddr (w_wrAddr),
    .i_wrData ({di_re, di_im}),
    .i_rdEn   (w_issue),
    .i_rdAddr (w_rdAddr),
    .o_rdData (w_ramQ)
  );

  // The data register only loads under a valid strobe so outputs hold between frames.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_issueD <= 1'b0;
      do_en    <= 1'b0;
      do_re    <= '0;
      do_im    <= '0;
    end else begin
      r_issueD <= w_issue;
      do_en    <= r_issueD;
      if (r_issueD) begin
        do_re <= w_ramQ[2*WIDTH-1:WIDTH];
        do_im <= w_ramQ[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_fft_reorder.sv
// Scoreboard bench for fft_reorder: frames of random or ramp data are queued
// as natural-order expectations with their due cycle; a monitor pops on do_en.
module tb_fft_reorder;

  localparam int  N      = 16;
  localparam int  WIDTH  = 16;
  localparam int  LOG_N  = 4;
  localparam time PERIOD = 10;

  typedef struct {
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
    int               cyc;
  } expT;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             diEn  = 1'b0;
  logic [WIDTH-1:0] diRe  = '0;
  logic [WIDTH-1:0] diIm  = '0;
  logic             doEn;
  logic [WIDTH-1:0] doRe;
  logic [WIDTH-1:0] doIm;

  expT              expQ[$];
  int               cycle    = 0;
  int               checks   = 0;
  int               failures = 0;
  logic [WIDTH-1:0] lastRe   = '0;
  logic [WIDTH-1:0] lastIm   = '0;

  fft_reorder #(.N(N), .WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .di_en (diEn),
    .di_re (diRe),
    .di_im (diIm),
    .do_en (doEn),
    .do_re (doRe),
    .do_im (doIm)
  );

  always #(PERIOD / 2) clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  // Index whose LOG_N-digit binary spelling is the reverse of v's.
  function automatic int bitRev(input int v);
    int r;
    int x;
    r = 0;
    x = v;
    for (int b = 0; b < LOG_N; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Drives 'len' samples; only a complete frame is queued for output.
  task automatic applyStimulus(input int len, input bit ramp);
    logic [WIDTH-1:0] frameRe [N];
    logic [WIDTH-1:0] frameIm [N];
    int startEdge;
    startEdge = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge clock);
      if (k == 0) startEdge = cycle + 1;
      frameRe[k] = ramp ? WIDTH'(k) : WIDTH'($urandom);
      frameIm[k] = ramp ? WIDTH'(-k) : WIDTH'($urandom);
      diEn = 1'b1;
      diRe = frameRe[k];
      diIm = frameIm[k];
    end
    if (len == N) begin
      for (int j = 0; j < N; j++) begin
        expQ.push_back('{frameRe[bitRev(j)], frameIm[bitRev(j)], startEdge + N + 1 + j});
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      diEn = 1'b0;
      diRe = WIDTH'($urandom);
      diIm = WIDTH'($urandom);
    end
  endtask

  task automatic checkOutput();
    expT e;
    if (doEn) begin
      if (expQ.size() == 0) begin
        compare("unexpected_do_en", 32'(doEn), 32'd0);
      end else begin
        e = expQ.pop_front();
        compare("out_cycle", 32'(cycle), 32'(e.cyc));
        compare("do_re", 32'(doRe), 32'(e.re));
        compare("do_im", 32'(doIm), 32'(e.im));
      end
      lastRe = doRe;
      lastIm = doIm;
    end else if (reset) begin
      compare("hold_re", 32'(doRe), 32'(lastRe));
      compare("hold_im", 32'(doIm), 32'(lastIm));
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #2;
      checkOutput();
    end
  end

  // A frame must never complete into a bank that is still waiting to be read.
  always @(negedge clock) begin
    #1;
    if (reset && diEn && (dut.r_wrCount == LOG_N'(N - 1))) begin
      compare("overflow_free_bank", 32'(dut.r_full[dut.r_wrBank]), 32'd0);
    end
  end

  initial begin
    #1 reset = 1'b0;
    idle(3);
    #1;
    compare("reset_do_en", 32'(doEn), 32'd0);
    compare("reset_do_re", 32'(doRe), 32'd0);
    compare("reset_do_im", 32'(doIm), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    idle(2);

    // Ramp frame: output j carries re = bitrev(j), im = -bitrev(j).
    applyStimulus(N, 1'b1);
    idle(N + 4);

    // Three back-to-back frames must stream out as one unbroken burst.
    repeat (3) applyStimulus(N, 1'b0);
    idle(4);

    applyStimulus(5, 1'b0);
    idle(2);
    applyStimulus(N, 1'b0);
    idle(N + 4);

    repeat (3) begin
      applyStimulus(N, 1'b0);
      idle(7);
    end
    idle(N + 4);

    // Reset while frame A is being output and frame B is half written.
    applyStimulus(N, 1'b0);
    applyStimulus(N / 2, 1'b0);
    #2;
    compare("pre_reset_do_en", 32'(doEn), 32'd1);
    reset = 1'b0;
    diEn  = 1'b0;
    #1;
    compare("async_reset_do_en", 32'(doEn), 32'd0);
    compare("async_reset_do_re", 32'(doRe), 32'd0);
    compare("async_reset_do_im", 32'(doIm), 32'd0);
    expQ.delete();
    lastRe = '0;
    lastIm = '0;
    @(negedge clock);
    reset = 1'b1;
    idle(2 * N);
    applyStimulus(N, 1'b0);
    idle(2);

    for (int f = 0; f < 24; f++) begin
      if ($urandom_range(0, 4) == 0) begin
        applyStimulus($urandom_range(1, N - 1), 1'b0);
        idle($urandom_range(1, 3));
      end
      applyStimulus(N, 1'b0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 8));
    end
    idle(1);

    for (int i = 0; i < 4 * N; i++) begin
      if (expQ.size() == 0) break;
      @(negedge clock);
    end
    idle(3);
    compare("drain_empty", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
